boot_copier: RTL and testbench



---
 rtl/boot_copier_pkg.sv | 13 +
 rtl/boot_copier.sv | 103 ++++++++++
 tb/tb_boot_copier.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_copier_pkg.sv
// Shared definitions for the boot ROM to RAM copier.
// The optional checksum is enabled with BOOT_COPIER_CHECKSUM_EN.
package boot_copier_pkg;

   typedef enum logic [1:0] {
      PRIME = 2'd0,
      COPY  = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [15:0] DEFAULT_DST_BASE = 16'hF800;

endpackage

// File: rtl/boot_copier.sv
// Copies COPY_LEN bytes from the boot ROM into RAM after reset, then releases the CPU.
// Define BOOT_COPIER_CHECKSUM_EN to build the running byte-sum accumulator.
module boot_copier
   import boot_copier_pkg::*;
#(
   parameter int          ROM_ADDR_W = 11,
   parameter int          COPY_LEN   = 2048,
   parameter logic [15:0] DST_BASE   = DEFAULT_DST_BASE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   input  logic [7:0]            rom_data,
   output logic [15:0]           ram_addr,
   output logic [7:0]            ram_wdata,
   output logic                  ram_we,
   input  logic                  ram_ready,
   output logic                  cpu_hold,
   output logic                  done,
   output logic [7:0]            checksum
);

   localparam int               IDX_W    = ROM_ADDR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COPY_LEN - 1);

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic             cpu_hold_q;
   logic             done_q;
   logic             accept;

   assign accept = (state_q == COPY) && ram_ready;

   // Look one byte ahead on accept so the registered ROM keeps pace at 1 byte/cycle.
   assign rom_addr  = accept ? (idx_q[ROM_ADDR_W-1:0] + ROM_ADDR_W'(1))
                             : idx_q[ROM_ADDR_W-1:0];
   assign ram_addr  = DST_BASE + 16'(idx_q);
   assign ram_wdata = rom_data;
   assign ram_we    = (state_q == COPY);
   assign cpu_hold  = cpu_hold_q;
   assign done      = done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= PRIME;
         idx_q      <= '0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            PRIME: state_q <= COPY;
            COPY: begin
               if (accept) begin
                  if (idx_q == LAST_IDX) begin
                     state_q    <= DONE;
                     cpu_hold_q <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            DONE: begin
               if (start) begin
                  state_q    <= PRIME;
                  idx_q      <= '0;
                  cpu_hold_q <= 1'b1;
                  done_q     <= 1'b0;
               end
            end
            default: state_q <= PRIME;
         endcase
      end
   end

`ifdef BOOT_COPIER_CHECKSUM_EN
   logic [7:0] checksum_q;
   logic [7:0] checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if ((state_q == DONE) && start) begin
         checksum_d = 8'h00;
      end else if (accept) begin
         checksum_d = checksum_q + rom_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         checksum_q <= 8'h00;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_boot_copier.sv
// Randomised bench for boot_copier: behavioural ROM, expected-write queue and a decoupled monitor.
// Covers reset release latency, stalls, mid-copy reset, start handling, address wrap and checksum.
module tb_boot_copier;

   localparam int          ROM_ADDR_W = 4;
   localparam int          COPY_LEN   = 6;
   localparam logic [15:0] DST_BASE   = 16'hFFFE;
   localparam int          ROM_DEPTH  = 1 << ROM_ADDR_W;
   localparam int          MAX_CYC    = 300;

   logic                  clk;
   logic                  reset;
   logic                  start;
   logic [ROM_ADDR_W-1:0] rom_addr;
   logic [7:0]            rom_data;
   logic [15:0]           ram_addr;
   logic [7:0]            ram_wdata;
   logic                  ram_we;
   logic                  ram_ready;
   logic                  cpu_hold;
   logic                  done;
   logic [7:0]            checksum;

   logic [7:0]  rom_mem [ROM_DEPTH];
   logic [23:0] exp_q [$];
   int          errors;
   int          checks;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Boot ROM: address registered on each edge, data valid the following cycle.
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   boot_copier #(
      .ROM_ADDR_W (ROM_ADDR_W),
      .COPY_LEN   (COPY_LEN),
      .DST_BASE   (DST_BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_ready (ram_ready),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .checksum  (checksum)
   );

   // ---------------- reference model ----------------
   function automatic logic [15:0] addr_of(input int i);
      logic [15:0] a;
      a = DST_BASE + 16'(i);
      return a;
   endfunction

   function automatic logic [7:0] model_checksum();
      logic [7:0] s;
      s = 8'h00;
`ifdef BOOT_COPIER_CHECKSUM_EN
      for (int i = 0; i < COPY_LEN; i++) s = s + rom_mem[i];
`endif
      return s;
   endfunction

   task automatic push_run();
      for (int i = 0; i < COPY_LEN; i++) exp_q.push_back({addr_of(i), rom_mem[i]});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic        prev_stall;
   logic [15:0] prev_addr;
   logic [7:0]  prev_data;
   initial prev_stall = 1'b0;

   always @(negedge clk) begin
      if (prev_stall) begin
         check("stall_we", 32'(ram_we), 32'd1);
         check("stall_addr", 32'(ram_addr), 32'(prev_addr));
         check("stall_data", 32'(ram_wdata), 32'(prev_data));
      end
      if (ram_we === 1'b1 && ram_ready === 1'b1) begin
         check("hold_during_copy", {30'd0, cpu_hold, done}, 32'b10);
         if (exp_q.size() == 0) begin
            check("unexpected_write", {8'd0, ram_addr, ram_wdata}, 32'hFFFFFFFF);
         end else begin
            check("write", {8'd0, ram_addr, ram_wdata}, {8'd0, exp_q.pop_front()});
         end
      end
      prev_stall = (ram_we === 1'b1) && (ram_ready === 1'b0) && (reset === 1'b0);
      prev_addr  = ram_addr;
      prev_data  = ram_wdata;
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_image(input bit fixed);
      for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = 8'($urandom_range(0, 255));
      if (fixed) begin
         rom_mem[0] = 8'h11; rom_mem[1] = 8'h22; rom_mem[2] = 8'h33;
         rom_mem[3] = 8'h44; rom_mem[4] = 8'h55; rom_mem[5] = 8'h66;
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_we"}, 32'(ram_we), 32'd0);
      check({tag, "_hold_done"}, {30'd0, cpu_hold, done}, 32'b10);
      check({tag, "_checksum"}, 32'(checksum), 32'd0);
      check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
   endtask

   task automatic check_done_state(input string tag);
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_hold_done"}, {30'd0, cpu_hold, done}, 32'b01);
      check({tag, "_we"}, 32'(ram_we), 32'd0);
      check({tag, "_checksum"}, 32'(checksum), 32'(model_checksum()));
      step();
      step();
      check({tag, "_checksum_stable"}, 32'(checksum), 32'(model_checksum()));
      check({tag, "_still_done"}, {30'd0, cpu_hold, done}, 32'b01);
   endtask

   // Runs cycle by cycle until done; optional 3-cycle stall, start pulse and reset pulse.
   task automatic run_copy(input bit rnd, input int stall_idx, input int start_at,
                           input int reset_idx, output int cyc);
      bit stall_pend;
      bit rst_pend;
      int stall_left;
      stall_pend = (stall_idx >= 0);
      rst_pend   = (reset_idx >= 0);
      stall_left = 0;
      cyc = 0;
      while (done !== 1'b1 && cyc < MAX_CYC) begin
         ram_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (stall_left > 0) begin
            ram_ready = 1'b0;
            stall_left--;
         end else if (stall_pend && ram_we === 1'b1 && ram_addr == addr_of(stall_idx)) begin
            stall_pend = 1'b0;
            ram_ready  = 1'b0;
            stall_left = 2;
         end
         start = (cyc == start_at);
         if (rst_pend && ram_we === 1'b1 && ram_ready && ram_addr == addr_of(reset_idx)) begin
            rst_pend = 1'b0;
            step();
            start = 1'b0;
            reset = 1'b1;
            step();
            check_reset_state("midcopy_reset");
            exp_q.delete();
            push_run();
            reset = 1'b0;
            cyc   = 0;
         end
         step();
         cyc++;
      end
      start     = 1'b0;
      ram_ready = 1'b1;
      if (cyc >= MAX_CYC) check("copy_timeout", 32'(cyc), 32'(MAX_CYC - 1));
   endtask

   task automatic pulse_start(input string tag);
      push_run();
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, "_start_hold_done"}, {30'd0, cpu_hold, done}, 32'b10);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc;
      int first_we;
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      ram_ready = 1'b1;
      load_image(1'b1);
      repeat (3) step();
      check_reset_state("reset");

      // Fixed image, ready tied high: latency from reset release.
      push_run();
      reset    = 1'b0;
      first_we = 0;
      while (ram_we !== 1'b1 && first_we < 10) begin
         step();
         first_we++;
      end
      check("first_we_cycles", 32'(first_we), 32'd1);
      run_copy(1'b0, -1, -1, -1, cyc);
      check("done_latency", 32'(first_we + cyc), 32'(COPY_LEN + 1));
      check_done_state("run1");

      // Restart from DONE, 3-cycle stall on byte 1, start pulsed mid-copy.
      load_image(1'b0);
      pulse_start("run2");
      run_copy(1'b0, 1, 3, -1, cyc);
      check_done_state("run2");

      // Random backpressure with a reset pulse after writing byte 2.
      load_image(1'b0);
      pulse_start("run3");
      run_copy(1'b1, -1, -1, 2, cyc);
      check_done_state("run3");

      for (int r = 0; r < 4; r++) begin
         load_image(r == 0);
         pulse_start("rand");
         run_copy(1'b1, $urandom_range(0, COPY_LEN - 1), $urandom_range(1, 5), -1, cyc);
         check_done_state("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
